ps2_tx: RTL and testbench
=========================

PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 2500, clock-low inhibit length in clock cycles (100 us at 25 MHz).
REQ-002 Parameter START_HOLD, default 25, cycles with both lines low before clock release.
REQ-003 Parameter TIMEOUT_CYCLES, default 375000, abort limit in cycles, counted from clock release (15 ms).
REQ-004 clock  in  1  system clock, 25 MHz; sole clock domain.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps_clock_i  in  1  raw PS/2 clock line level, asynchronous.
REQ-007 ps_data_i  in  1  raw PS/2 data line level, asynchronous.
REQ-008 ps_clock_oe  out  1  1 = drive PS/2 clock low; 0 = release (top level ties pin to 1'bZ).
REQ-009 ps_data_oe  out  1  1 = drive PS/2 data low; 0 = release.
REQ-010 start  in  1  one-cycle request to send data.
REQ-011 data  in  8  byte to send, LSB first.
REQ-012 busy  out  1  transfer in progress; top level gates the ps2 receiver's done with it.
REQ-013 done  out  1  one-cycle pulse at transfer end, success or failure.
REQ-014 err  out  2  bit0 = no ACK from device; bit1 = timeout; held until next accepted start.

Function
REQ-015 ps_clock_i and ps_data_i SHALL pass through 2-flop synchronizers; a falling edge is synchronized clock previous=1, current=0.
REQ-016 States: IDLE, INHIBIT, STARTB, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe=0, busy=0; start=1 latches data, computes odd parity, clears err, and enters INHIBIT next cycle.
REQ-018 start while busy=1 SHALL be ignored; data changes after acceptance SHALL have no effect.
REQ-019 INHIBIT: ps_clock_oe=1, ps_data_oe=0 for exactly INHIBIT_CYCLES cycles, then STARTB.
REQ-020 STARTB: ps_clock_oe=1, ps_data_oe=1 for exactly START_HOLD cycles, then SEND with bit index 0.
REQ-021 SEND: ps_clock_oe=0, ps_data_oe=1 at entry (start bit); timeout counter clears and starts counting.
REQ-022 SEND, per falling edge: index 0-7 sets ps_data_oe=~data[index]; index 8 sets ps_data_oe=~parity; index 9 sets ps_data_oe=0 (stop bit) and enters ACK. Index increments per edge.
REQ-023 ps_data_oe SHALL update no later than 3 clock cycles after the ps_clock_i falling transition.
REQ-024 Parity SHALL make the total of ones in data plus parity odd.
REQ-025 ACK: on the next falling edge, sample synchronized data; 0 = ACK, 1 sets err[0]; enter WAIT_IDLE.
REQ-026 WAIT_IDLE: when synchronized clock=1 and data=1 in the same cycle, pulse done for one cycle and return to IDLE.
REQ-027 Timeout: if the counter reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, both oe go to 0, err[1] sets, done pulses, and state returns to IDLE. The counter saturates and never wraps.
REQ-028 busy=1 in every state except IDLE, including the done cycle's predecessor. busy=0 in the cycle done=1 and after.
REQ-029 A glitch-free edge sequence is assumed from the device. Extra falling edges beyond ACK are ignored in WAIT_IDLE.

Reset
REQ-030 reset=1 SHALL force, on the next clock edge: state IDLE, ps_clock_oe=0, ps_data_oe=0, busy=0, done=0, err=0, counters 0, synchronizers 1.
REQ-031 reset mid-transfer SHALL release both lines immediately, with no done pulse.

Verification
REQ-032 data=0xED, start; device model clocks at 12.5 kHz and ACKs. Required: clock low for 2500 cycles; then 25 cycles both low; then bits 1,0,1,1,0,1,1,1, parity 1, stop 1 seen on rising edges; done=1, err=0.
REQ-033 data=0xF4: parity bit observed = 0; done=1, err=0.
REQ-034 Device never ACKs (data stays 1 at 11th falling edge): done=1, err=2'b01.
REQ-035 Device never clocks after release: after 375000 cycles, both oe=0, done=1, err=2'b10, busy=0.
REQ-036 start pulsed again during SEND with data=0x00: the transmitted byte remains the first one. Then reset asserted at bit 5: next cycle oe=0/0, busy=0, no done.

Source files
------------

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_tx
// Purpose  : PS/2 host-to-device byte transmitter (inhibit, request, 11-bit
//            frame, ACK check, timeout abort) driving open-drain enables.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int START_HOLD     = 25,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps_clock_i,
    input  logic       ps_data_i,
    output logic       ps_clock_oe,
    output logic       ps_data_oe,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int PHASE_MAX = (INHIBIT_CYCLES > START_HOLD) ? INHIBIT_CYCLES : START_HOLD;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] HOLD_LAST    = PW'(START_HOLD - 1);
    localparam logic [TW-1:0] TMO_LIMIT    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        STARTB    = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    state_t        state;
    logic [2:0]    clk_sync;   // [1] = current synchronized level, [2] = previous
    logic [1:0]    dat_sync;
    logic [PW-1:0] cnt;
    logic [TW-1:0] tmo;
    logic [3:0]    idx;
    logic [7:0]    shreg;
    logic          parity;
    logic          ps_fall;

    assign ps_fall = clk_sync[2] & ~clk_sync[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync <= 3'b111;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[1:0], ps_clock_i};
            dat_sync <= {dat_sync[0], ps_data_i};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ps_clock_oe <= 1'b0;
            ps_data_oe  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 2'b00;
            cnt         <= '0;
            tmo         <= '0;
            idx         <= 4'd0;
            shreg       <= 8'h00;
            parity      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= data;
                        parity      <= ~^data;
                        err         <= 2'b00;
                        cnt         <= '0;
                        ps_clock_oe <= 1'b1;
                        busy        <= 1'b1;
                        state       <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt == INHIBIT_LAST) begin
                        cnt        <= '0;
                        ps_data_oe <= 1'b1;
                        state      <= STARTB;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                STARTB: begin
                    if (cnt == HOLD_LAST) begin
                        cnt         <= '0;
                        ps_clock_oe <= 1'b0;
                        idx         <= 4'd0;
                        tmo         <= '0;
                        state       <= SEND;
                    end else begin
                        cnt <= cnt + PW'(1);
                    end
                end
                default: begin
                    // Device-clocked phases share one abort path; tmo stops at the limit.
                    if (tmo == TMO_LIMIT) begin
                        ps_clock_oe <= 1'b0;
                        ps_data_oe  <= 1'b0;
                        err[1]      <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                        case (state)
                            SEND: begin
                                if (ps_fall) begin
                                    idx <= idx + 4'd1;
                                    if (idx < 4'd8) begin
                                        ps_data_oe <= ~shreg[idx[2:0]];
                                    end else if (idx == 4'd8) begin
                                        ps_data_oe <= ~parity;
                                    end else begin
                                        ps_data_oe <= 1'b0;
                                        state      <= ACK;
                                    end
                                end
                            end
                            ACK: begin
                                if (ps_fall) begin
                                    if (dat_sync[1]) begin
                                        err[0] <= 1'b1;
                                    end
                                    state <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_sync[1] && dat_sync[1]) begin
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                    state <= IDLE;
                                end
                            end
                            default: begin
                                ps_clock_oe <= 1'b0;
                                ps_data_oe  <= 1'b0;
                                busy        <= 1'b0;
                                state       <= IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_tx
// Purpose  : Self-checking bench for ps2_tx with an open-drain PS/2 device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

    localparam int INH  = 300;
    localparam int HOLD = 25;
    localparam int TMO  = 4000;
    localparam int HALF = 40;
    localparam int NVEC = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       dev_clk_low  = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps_clock_i, ps_data_i;
    logic       ps_clock_oe, ps_data_oe, busy, done;
    logic [1:0] err;

    assign ps_clock_i = ~(ps_clock_oe | dev_clk_low);
    assign ps_data_i  = ~(ps_data_oe | dev_data_low);

    ps2_tx #(.INHIBIT_CYCLES(INH), .START_HOLD(HOLD), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .ps_clock_i(ps_clock_i), .ps_data_i(ps_data_i),
        .ps_clock_oe(ps_clock_oe), .ps_data_oe(ps_data_oe), .start(start), .data(data),
        .busy(busy), .done(done), .err(err)
    );

    always #20 clock = ~clock;

    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    logic busy_q = 1'b0;
    logic busy_before_done = 1'b0;

    always @(negedge clock) begin
        if (done) begin
            done_cnt = done_cnt + 1;
            busy_before_done = busy_q;
        end
        busy_q = busy;
    end

    typedef struct {
        logic [7:0] d;
        logic       ack;
        logic [1:0] exp_err;
        logic       exp_par;
    } vec_t;

    vec_t vt[NVEC];

    // Odd parity from the ones count: parity is 1 exactly when the byte has an even count.
    function automatic logic model_parity(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic begin_tx(input logic [7:0] b);
        @(negedge clock);
        data  = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        data  = 8'($urandom);
    endtask

    task automatic measure_request(output int inh, output int hold);
        inh  = 0;
        hold = 0;
        while (ps_clock_oe && !ps_data_oe && inh < 2 * INH) begin
            inh = inh + 1;
            @(negedge clock);
        end
        while (ps_clock_oe && ps_data_oe && hold < 2 * HOLD) begin
            hold = hold + 1;
            @(negedge clock);
        end
    endtask

    // One device clock pulse; the bit is whatever the line carries at the rising edge.
    task automatic dev_bit(output logic b);
        tick(HALF);
        dev_clk_low = 1'b1;
        tick(HALF);
        b = ps_data_i;
        dev_clk_low = 1'b0;
    endtask

    task automatic run_frame(input logic ack, output logic [9:0] bits);
        logic dummy;
        for (int i = 0; i < 10; i++) begin
            dev_bit(bits[i]);
        end
        dev_data_low = ack;
        dev_bit(dummy);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int waited, output logic seen);
        waited = 0;
        seen   = 1'b0;
        while (!done && waited < budget) begin
            waited = waited + 1;
            @(negedge clock);
        end
        seen = done;
    endtask

    initial begin
        int         inh, hold, waited, dc;
        logic       seen;
        logic [9:0] bits;

        vt[0] = '{d: 8'hED, ack: 1'b1, exp_err: 2'b00, exp_par: 1'b1};
        vt[1] = '{d: 8'hF4, ack: 1'b1, exp_err: 2'b00, exp_par: 1'b0};
        vt[2] = '{d: 8'h00, ack: 1'b0, exp_err: 2'b01, exp_par: 1'b1};
        vt[3] = '{d: 8'hFF, ack: 1'b1, exp_err: 2'b00, exp_par: 1'b1};
        for (int i = 4; i < NVEC; i++) begin
            vt[i].d       = 8'($urandom);
            vt[i].ack     = 1'($urandom_range(0, 3) != 0);
            vt[i].exp_err = vt[i].ack ? 2'b00 : 2'b01;
            vt[i].exp_par = model_parity(vt[i].d);
        end

        tick(3);
        check("reset_clock_oe", ps_clock_oe, 0);
        check("reset_data_oe", ps_data_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        reset = 1'b0;
        tick(2);

        for (int v = 0; v < NVEC; v++) begin
            dc = done_cnt;
            begin_tx(vt[v].d);
            check("busy_after_start", busy, 1);
            measure_request(inh, hold);
            check("inhibit_len", inh, INH);
            check("start_hold_len", hold, HOLD);
            run_frame(vt[v].ack, bits);
            check("data_bits", bits[7:0], vt[v].d);
            check("parity_bit", bits[8], vt[v].exp_par);
            check("parity_model", bits[8], model_parity(vt[v].d));
            check("stop_bit", bits[9], 1);
            wait_done(20, waited, seen);
            check("done_seen", seen, 1);
            check("err_at_done", err, vt[v].exp_err);
            check("busy_at_done", busy, 0);
            tick(3);
            check("busy_before_done", busy_before_done, 1);
            check("done_pulses", done_cnt - dc, 1);
            check("err_held", err, vt[v].exp_err);
            check("idle_clock_oe", ps_clock_oe, 0);
            check("idle_data_oe", ps_data_oe, 0);
        end

        // Device never clocks after the request.
        begin_tx(8'h3C);
        measure_request(inh, hold);
        wait_done(TMO + 50, waited, seen);
        check("tmo_done_seen", seen, 1);
        check("tmo_delay_in_range", int'(waited >= TMO && waited <= TMO + 2), 1);
        check("tmo_err", err, 2);
        check("tmo_clock_oe", ps_clock_oe, 0);
        check("tmo_data_oe", ps_data_oe, 0);
        check("tmo_busy", busy, 0);
        tick(3);

        // Restart during SEND is ignored, then reset lands mid-frame.
        begin_tx(8'hA5);
        measure_request(inh, hold);
        tick(3);
        data  = 8'h00;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            dev_bit(bits[i]);
        end
        check("restart_ignored_bits", bits[4:0], 5'h05);
        check("mid_busy", busy, 1);
        tick(HALF);
        dev_clk_low = 1'b1;
        tick(5);
        dc = done_cnt;
        reset = 1'b1;
        tick(1);
        check("rst_mid_clock_oe", ps_clock_oe, 0);
        check("rst_mid_data_oe", ps_data_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        reset = 1'b0;
        dev_clk_low = 1'b0;
        tick(200);
        check("rst_mid_no_done", done_cnt - dc, 0);
        check("rst_mid_idle_clock_oe", ps_clock_oe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
